// File: rtl/writeback_queue_if.sv
// Memory-stage issue, data-memory response and register-file write bundle for writeback_queue.
// slave is the block's view; master is the driving environment's view.
interface writeback_queue_if #(
   parameter int unsigned XLEN     = 64,
   parameter int unsigned LQ_DEPTH = 4
);
   localparam int unsigned AW = $clog2(XLEN / 8);
   localparam int unsigned CW = $clog2(LQ_DEPTH) + 1;

   logic            valid_i;
   logic            ready_o;
   logic            squash_i;
   logic [XLEN-1:0] rd_data_i;
   logic [4:0]      rd_idx_i;
   logic            rd_wr_en_i;
   logic            is_load_i;
   logic [3:0]      mem_width_1h_i;
   logic            mem_sign_i;
   logic [AW-1:0]   byte_addr_i;
   logic            dmem_rvalid_i;
   logic [XLEN-1:0] dmem_rdata_i;
   logic [XLEN-1:0] rd_data_o;
   logic [4:0]      rd_idx_o;
   logic            rd_wr_en_o;
   logic [31:0]     busy_o;
   logic [CW-1:0]   lq_count_o;
   logic            err_o;

   modport slave (
      input  valid_i, squash_i, rd_data_i, rd_idx_i, rd_wr_en_i, is_load_i,
      input  mem_width_1h_i, mem_sign_i, byte_addr_i, dmem_rvalid_i, dmem_rdata_i,
      output ready_o, rd_data_o, rd_idx_o, rd_wr_en_o, busy_o, lq_count_o, err_o
   );

   modport master (
      output valid_i, squash_i, rd_data_i, rd_idx_i, rd_wr_en_i, is_load_i,
      output mem_width_1h_i, mem_sign_i, byte_addr_i, dmem_rvalid_i, dmem_rdata_i,
      input  ready_o, rd_data_o, rd_idx_o, rd_wr_en_o, busy_o, lq_count_o, err_o
   );
endinterface

// File: rtl/writeback_queue.sv
// Writeback stage: non-load results retire immediately, issued loads wait in a FIFO load queue
// until their in-order memory response arrives, then are sliced/extended and written back.
module writeback_queue #(
   parameter int unsigned XLEN     = 64,
   parameter int unsigned LQ_DEPTH = 4
) (
   input logic              clk_i,
   input logic              rst_i,
   writeback_queue_if.slave wb
);
   localparam int unsigned AW = $clog2(XLEN / 8);
   localparam int unsigned PW = $clog2(LQ_DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef struct packed {
      logic [4:0]    idx;
      logic          wen;
      logic [3:0]    width;
      logic          sign;
      logic [AW-1:0] addr;
      logic          bad;
   } lq_entry_t;

   lq_entry_t           lq_q [LQ_DEPTH];
   logic [LQ_DEPTH-1:0] lq_vld_q;
   logic [PW-1:0]       head_q;
   logic [PW-1:0]       tail_q;
   logic [CW-1:0]       count_q;
   logic                err_q;

   logic            lq_full;
   logic            lq_empty;
   logic            accept;
   logic            push;
   logic            pop;
   logic            width_bad;
   logic            hazard;
   logic            err_set;
   logic [31:0]     busy;
   lq_entry_t       push_entry;
   lq_entry_t       head;
   logic [AW-1:0]   align_mask;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] load_data;
   int unsigned     nbits;
   logic            sbit;

   assign lq_full  = (count_q == CW'(LQ_DEPTH));
   assign lq_empty = (count_q == '0);

   // A response owns the single write port, so acceptance is blocked in that cycle.
   assign wb.ready_o = ~rst_i & ~lq_full & ~wb.dmem_rvalid_i;
   assign accept     = wb.valid_i & wb.ready_o & ~wb.squash_i;
   assign push       = accept & wb.is_load_i;
   assign pop        = ~rst_i & wb.dmem_rvalid_i & ~lq_empty;

   assign width_bad = ~$onehot(wb.mem_width_1h_i) | (wb.mem_width_1h_i[3] & (XLEN == 32));
   assign hazard    = accept & wb.rd_wr_en_i & busy[wb.rd_idx_i];
   assign err_set   = (wb.dmem_rvalid_i & lq_empty) | hazard | (push & width_bad);

   always_comb begin
      push_entry       = '0;
      push_entry.idx   = wb.rd_idx_i;
      push_entry.wen   = wb.rd_wr_en_i & (wb.rd_idx_i != 5'd0);
      push_entry.width = wb.mem_width_1h_i;
      push_entry.sign  = wb.mem_sign_i;
      push_entry.addr  = wb.byte_addr_i;
      push_entry.bad   = width_bad;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         lq_vld_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (push) begin
            lq_vld_q[tail_q] <= 1'b1;
            tail_q           <= tail_q + 1'b1;
         end
         if (pop) begin
            lq_vld_q[head_q] <= 1'b0;
            head_q           <= head_q + 1'b1;
         end
         if (push) begin
            count_q <= count_q + 1'b1;
         end else if (pop) begin
            count_q <= count_q - 1'b1;
         end
         if (err_set) begin
            err_q <= 1'b1;
         end
      end
   end

   // Payload needs no reset: it is only observed through lq_vld_q.
   always_ff @(posedge clk_i) begin
      if (push) begin
         lq_q[tail_q] <= push_entry;
      end
   end

   assign head = lq_q[head_q];

   // Clearing the low address bits selects the naturally aligned lane for each width.
   always_comb begin
      align_mask = '1;
      nbits      = XLEN;
      if (head.width[0]) begin
         nbits = 8;
      end else if (head.width[1]) begin
         align_mask = ~AW'(1);
         nbits      = 16;
      end else if (head.width[2]) begin
         align_mask = ~AW'(3);
         nbits      = 32;
      end else begin
         align_mask = '0;
      end
   end

   assign shifted = wb.dmem_rdata_i >> {head.addr & align_mask, 3'b000};

   always_comb begin
      if (head.width[0]) begin
         sbit = head.sign & shifted[7];
      end else if (head.width[1]) begin
         sbit = head.sign & shifted[15];
      end else if (head.width[2]) begin
         sbit = head.sign & shifted[31];
      end else begin
         sbit = head.sign & shifted[XLEN-1];
      end
   end

   always_comb begin
      load_data = '0;
      if (!head.bad) begin
         for (int unsigned i = 0; i < XLEN; i++) begin
            load_data[i] = (i < nbits) ? shifted[i] : sbit;
         end
      end
   end

   always_comb begin
      wb.rd_wr_en_o = 1'b0;
      wb.rd_idx_o   = wb.rd_idx_i;
      wb.rd_data_o  = wb.rd_data_i;
      if (pop) begin
         wb.rd_wr_en_o = head.wen;
         wb.rd_idx_o   = head.idx;
         wb.rd_data_o  = load_data;
      end else if (accept && !wb.is_load_i) begin
         wb.rd_wr_en_o = wb.rd_wr_en_i & (wb.rd_idx_i != 5'd0);
      end
   end

   always_comb begin
      busy = '0;
      for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
         if (lq_vld_q[i] && lq_q[i].wen) begin
            busy[lq_q[i].idx] = 1'b1;
         end
      end
      busy[0] = 1'b0;
   end

   assign wb.busy_o     = busy;
   assign wb.lq_count_o = count_q;
   assign wb.err_o      = err_q;
endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue (XLEN 64 and 32 instances) with a write scoreboard.
module tb_writeback_queue;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   writeback_queue_if #(.XLEN(64), .LQ_DEPTH(4)) b64 ();
   writeback_queue_if #(.XLEN(32), .LQ_DEPTH(4)) b32 ();

   writeback_queue #(.XLEN(64), .LQ_DEPTH(4)) u64 (.clk_i(clk), .rst_i(rst), .wb(b64.slave));
   writeback_queue #(.XLEN(32), .LQ_DEPTH(4)) u32 (.clk_i(clk), .rst_i(rst), .wb(b32.slave));

   typedef struct packed {
      logic [4:0] idx;
      logic [3:0] w;
      logic       s;
      logic [2:0] a;
   } ld_t;

   typedef struct packed {
      logic [4:0]  idx;
      logic [63:0] data;
   } wr_t;

   ld_t pend[$];
   wr_t sb[$];
   int  checks = 0;
   int  errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference slicing written from the lane-index description.
   function automatic logic [63:0] model64(input logic [63:0] d, input ld_t l);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] w;
      b = d[8*l.a +: 8];
      h = d[16*l.a[2:1] +: 16];
      w = d[32*l.a[2] +: 32];
      case (l.w)
         4'b0001: return {{56{l.s & b[7]}}, b};
         4'b0010: return {{48{l.s & h[15]}}, h};
         4'b0100: return {{32{l.s & w[31]}}, w};
         4'b1000: return d;
         default: return 64'd0;
      endcase
   endfunction

   task automatic idle64();
      b64.valid_i = 0; b64.squash_i = 0; b64.rd_data_i = '0; b64.rd_idx_i = '0;
      b64.rd_wr_en_i = 0; b64.is_load_i = 0; b64.mem_width_1h_i = '0; b64.mem_sign_i = 0;
      b64.byte_addr_i = '0; b64.dmem_rvalid_i = 0; b64.dmem_rdata_i = '0;
   endtask

   task automatic idle32();
      b32.valid_i = 0; b32.squash_i = 0; b32.rd_data_i = '0; b32.rd_idx_i = '0;
      b32.rd_wr_en_i = 0; b32.is_load_i = 0; b32.mem_width_1h_i = '0; b32.mem_sign_i = 0;
      b32.byte_addr_i = '0; b32.dmem_rvalid_i = 0; b32.dmem_rdata_i = '0;
   endtask

   task automatic observe();
      wr_t w;
      if (b64.rd_wr_en_o === 1'b1) begin
         checks++;
         assert (sb.size() > 0)
         else begin
            errors++;
            $error("FAIL sb_unexpected_write: observed idx %0d data %0h expected no write",
                   b64.rd_idx_o, b64.rd_data_o);
         end
         if (sb.size() > 0) begin
            w = sb.pop_front();
            chk("sb_idx", 64'(b64.rd_idx_o), 64'(w.idx));
            chk("sb_data", b64.rd_data_o, w.data);
         end
      end
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic tick();
      observe();
      @(posedge clk);
      #1;
   endtask

   task automatic push_wr(input logic [4:0] idx, input logic [63:0] data);
      wr_t w;
      w.idx  = idx;
      w.data = data;
      sb.push_back(w);
   endtask

   task automatic issue_load64(input logic [4:0] idx, input logic [3:0] w, input logic s,
                               input logic [2:0] a);
      ld_t l;
      b64.valid_i = 1; b64.is_load_i = 1; b64.rd_wr_en_i = 1; b64.rd_idx_i = idx;
      b64.mem_width_1h_i = w; b64.mem_sign_i = s; b64.byte_addr_i = a;
      settle();
      chk("issue_ready", 64'(b64.ready_o), 64'd1);
      chk("issue_no_write", 64'(b64.rd_wr_en_o), 64'd0);
      tick();
      l.idx = idx; l.w = w; l.s = s; l.a = a;
      pend.push_back(l);
      idle64();
   endtask

   task automatic respond64(input logic [63:0] data);
      ld_t l;
      l = pend.pop_front();
      push_wr(l.idx, model64(data, l));
      b64.dmem_rvalid_i = 1;
      b64.dmem_rdata_i  = data;
      settle();
      chk("resp_ready_low", 64'(b64.ready_o), 64'd0);
      chk("resp_wen", 64'(b64.rd_wr_en_o), 64'(l.idx != 5'd0));
      tick();
      b64.dmem_rvalid_i = 0;
   endtask

   initial begin
      logic [3:0] w_tab [4];
      ld_t        l;
      w_tab[0] = 4'b0001; w_tab[1] = 4'b0010; w_tab[2] = 4'b0100; w_tab[3] = 4'b1000;
      idle64();
      idle32();

      // Reset holds ready and write-enable low even with a valid non-load presented
      rst = 1;
      b64.valid_i = 1; b64.rd_wr_en_i = 1; b64.rd_idx_i = 5; b64.rd_data_i = 64'h55;
      settle();
      chk("rst_ready", 64'(b64.ready_o), 64'd0);
      chk("rst_wen", 64'(b64.rd_wr_en_o), 64'd0);
      tick();
      tick();
      rst = 0;
      idle64();
      settle();
      chk("rst_count", 64'(b64.lq_count_o), 64'd0);
      chk("rst_busy", 64'(b64.busy_o), 64'd0);
      chk("rst_err", 64'(b64.err_o), 64'd0);
      chk("rst_ready_after", 64'(b64.ready_o), 64'd1);
      tick();

      // Non-load writeback, then rd=0
      b64.valid_i = 1; b64.rd_wr_en_i = 1; b64.rd_idx_i = 5; b64.rd_data_i = 64'h1234;
      push_wr(5, 64'h1234);
      settle();
      chk("nl_wen", 64'(b64.rd_wr_en_o), 64'd1);
      tick();
      b64.rd_idx_i = 0;
      settle();
      chk("nl_rd0_wen", 64'(b64.rd_wr_en_o), 64'd0);
      tick();
      idle64();

      // Signed byte load, response three cycles after issue
      issue_load64(3, 4'b0001, 1, 6);
      settle();
      chk("ld_busy3", 64'(b64.busy_o[3]), 64'd1);
      chk("ld_count1", 64'(b64.lq_count_o), 64'd1);
      tick();
      settle();
      chk("ld_busy3_hold", 64'(b64.busy_o[3]), 64'd1);
      tick();
      respond64(64'h0080_0000_0000_0000);
      settle();
      chk("ld_busy3_clear", 64'(b64.busy_o[3]), 64'd0);
      chk("ld_count0", 64'(b64.lq_count_o), 64'd0);
      tick();
      chk("ld_signed_pair", sb.size(), 0);
      push_wr(31, 64'd0);
      void'(sb.pop_back());

      // Unsigned variant
      issue_load64(3, 4'b0001, 0, 6);
      tick();
      respond64(64'h0080_0000_0000_0000);

      // Fill, full, drain one, and wrap over 10 loads
      for (int k = 0; k < 4; k++) begin
         issue_load64(5'(8 + k), w_tab[k % 4], k[0], 3'($urandom_range(0, 7)));
      end
      settle();
      chk("full_count", 64'(b64.lq_count_o), 64'd4);
      chk("full_ready", 64'(b64.ready_o), 64'd0);
      tick();
      respond64({$urandom(), $urandom()});
      settle();
      chk("after_pop_ready", 64'(b64.ready_o), 64'd1);
      chk("after_pop_count", 64'(b64.lq_count_o), 64'd3);
      for (int k = 4; k < 10; k++) begin
         issue_load64(5'(8 + k), w_tab[k % 4], k[1], 3'($urandom_range(0, 7)));
         respond64({$urandom(), $urandom()});
      end
      for (int k = 0; k < 3; k++) begin
         respond64({$urandom(), $urandom()});
      end
      settle();
      chk("wrap_count", 64'(b64.lq_count_o), 64'd0);
      chk("wrap_busy", 64'(b64.busy_o), 64'd0);
      chk("wrap_err", 64'(b64.err_o), 64'd0);
      tick();

      // Response collides with a valid non-load: load wins, non-load accepted next cycle
      issue_load64(20, 4'b0100, 0, 4);
      l = pend.pop_front();
      push_wr(l.idx, model64(64'hCAFE_F00D_1234_5678, l));
      b64.dmem_rvalid_i = 1; b64.dmem_rdata_i = 64'hCAFE_F00D_1234_5678;
      b64.valid_i = 1; b64.rd_wr_en_i = 1; b64.rd_idx_i = 21; b64.rd_data_i = 64'hABCD;
      settle();
      chk("coll_ready", 64'(b64.ready_o), 64'd0);
      chk("coll_idx", 64'(b64.rd_idx_o), 64'd20);
      tick();
      b64.dmem_rvalid_i = 0;
      push_wr(21, 64'hABCD);
      settle();
      chk("coll_ready_next", 64'(b64.ready_o), 64'd1);
      chk("coll_idx_next", 64'(b64.rd_idx_o), 64'd21);
      tick();
      idle64();

      // Squashed load pushes nothing
      b64.valid_i = 1; b64.is_load_i = 1; b64.squash_i = 1; b64.rd_wr_en_i = 1;
      b64.rd_idx_i = 9; b64.mem_width_1h_i = 4'b0001;
      settle();
      chk("squash_wen", 64'(b64.rd_wr_en_o), 64'd0);
      tick();
      idle64();
      settle();
      chk("squash_count", 64'(b64.lq_count_o), 64'd0);
      chk("squash_busy", 64'(b64.busy_o), 64'd0);
      chk("pre_empty_err", 64'(b64.err_o), 64'd0);
      tick();

      // XLEN=32: signed half, then double width flagged with zero data
      b32.valid_i = 1; b32.is_load_i = 1; b32.rd_wr_en_i = 1; b32.rd_idx_i = 4;
      b32.mem_width_1h_i = 4'b0010; b32.mem_sign_i = 1; b32.byte_addr_i = 2;
      settle();
      tick();
      idle32();
      settle();
      tick();
      b32.dmem_rvalid_i = 1; b32.dmem_rdata_i = 32'h8001_0000;
      settle();
      chk("x32_half_wen", 64'(b32.rd_wr_en_o), 64'd1);
      chk("x32_half_idx", 64'(b32.rd_idx_o), 64'd4);
      chk("x32_half_data", 64'(b32.rd_data_o), 64'h0000_0000_FFFF_8001);
      tick();
      idle32();
      settle();
      chk("x32_err_clean", 64'(b32.err_o), 64'd0);
      b32.valid_i = 1; b32.is_load_i = 1; b32.rd_wr_en_i = 1; b32.rd_idx_i = 6;
      b32.mem_width_1h_i = 4'b1000;
      tick();
      idle32();
      settle();
      chk("x32_dbl_err", 64'(b32.err_o), 64'd1);
      b32.dmem_rvalid_i = 1; b32.dmem_rdata_i = 32'hDEAD_BEEF;
      settle();
      chk("x32_dbl_wen", 64'(b32.rd_wr_en_o), 64'd1);
      chk("x32_dbl_data", 64'(b32.rd_data_o), 64'd0);
      tick();
      idle32();

      // Response with empty queue: no write, sticky error
      b64.dmem_rvalid_i = 1; b64.dmem_rdata_i = 64'h1111;
      settle();
      chk("empty_resp_wen", 64'(b64.rd_wr_en_o), 64'd0);
      tick();
      idle64();
      settle();
      chk("empty_resp_err", 64'(b64.err_o), 64'd1);
      tick();

      // Reset with loads pending
      issue_load64(25, 4'b0001, 0, 0);
      issue_load64(26, 4'b0010, 0, 0);
      settle();
      chk("mid_count", 64'(b64.lq_count_o), 64'd2);
      chk("mid_busy", 64'(b64.busy_o), 64'h0600_0000);
      rst = 1;
      settle();
      chk("mid_rst_ready", 64'(b64.ready_o), 64'd0);
      tick();
      settle();
      chk("mid_rst_count", 64'(b64.lq_count_o), 64'd0);
      chk("mid_rst_busy", 64'(b64.busy_o), 64'd0);
      chk("mid_rst_err", 64'(b64.err_o), 64'd0);
      tick();
      rst = 0;
      pend.delete();

      // Non-one-hot width: error, entry still retires with zero data
      issue_load64(9, 4'b0011, 0, 0);
      settle();
      chk("bad_width_err", 64'(b64.err_o), 64'd1);
      tick();
      respond64(64'hFFFF_FFFF_FFFF_FFFF);
      rst = 1;
      settle();
      tick();
      rst = 0;
      settle();
      chk("rst2_err", 64'(b64.err_o), 64'd0);
      tick();

      // Write to a busy register: error, write still happens
      issue_load64(7, 4'b1000, 0, 0);
      b64.valid_i = 1; b64.rd_wr_en_i = 1; b64.rd_idx_i = 7; b64.rd_data_i = 64'h77;
      push_wr(7, 64'h77);
      settle();
      chk("hazard_wen", 64'(b64.rd_wr_en_o), 64'd1);
      tick();
      idle64();
      settle();
      chk("hazard_err", 64'(b64.err_o), 64'd1);
      tick();
      respond64(64'h0123_4567_89AB_CDEF);
      settle();
      chk("final_count", 64'(b64.lq_count_o), 64'd0);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
